// File: rtl/traffic_pkg.sv
// Shared phase-state and light encodings for the intersection phase scheduler.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'b00,
        YELLOW  = 2'b01,
        ALL_RED = 2'b10,
        WALK    = 2'b11
    } phase_e;

    localparam logic [2:0] LIGHT_G = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_R = 3'b001;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after base, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic          valid,
    output logic [IW-1:0] idx
);

    int p;

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        valid = 1'b0;
        idx   = base;
        p     = 0;
        for (int k = N; k >= 1; k--) begin
            p = (int'(base) + k) % N;
            if (req[p]) begin
                valid = 1'b1;
                idx   = IW'(p);
            end
        end
    end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Round-robin N-approach green scheduler with min/max green, yellow, all-red.
// Define PED_WALK_EN to add the pedestrian WALK phase (ped_req / walk).
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N_APPROACH  = 4,
    parameter int MIN_GREEN   = 80,
    parameter int MAX_GREEN   = 160,
    parameter int YELLOW_CYC  = 20,
    parameter int ALL_RED_CYC = 1,
    parameter int CNT_W       = 8,
`ifdef PED_WALK_EN
    parameter int WALK_CYC    = 40,
`endif
    parameter int IW          = $clog2(N_APPROACH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_APPROACH-1:0]   car_req,
`ifdef PED_WALK_EN
    input  logic                    ped_req,
    output logic                    walk,
`endif
    output logic [3*N_APPROACH-1:0] light,
    output logic [IW-1:0]           grant_idx,
    output logic [1:0]              phase_state
);

    phase_e state_q, state_d;
    logic [IW-1:0] cur_q, cur_d;
    logic [IW-1:0] nxt_q, nxt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_lim;
    logic [N_APPROACH-1:0] other_req;
    logic pick_valid;
    logic [IW-1:0] pick_idx;
    logic green_exit;
`ifdef PED_WALK_EN
    logic ped_pend_q, ped_pend_d;
`endif

    assign other_req = car_req
        & ~({{(N_APPROACH-1){1'b0}}, 1'b1} << cur_q);

    rr_pick #(
        .N  (N_APPROACH),
        .IW (IW)
    ) u_pick (
        .req   (other_req),
        .base  (cur_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GREEN;
            cur_q      <= '0;
            nxt_q      <= '0;
            cnt_q      <= '0;
`ifdef PED_WALK_EN
            ped_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            cnt_q      <= cnt_d;
`ifdef PED_WALK_EN
            ped_pend_q <= ped_pend_d;
`endif
        end
    end

    always_comb begin
        cnt_lim = CNT_W'(MAX_GREEN - 1);
        case (state_q)
            YELLOW:  cnt_lim = CNT_W'(YELLOW_CYC - 1);
            ALL_RED: cnt_lim = CNT_W'(ALL_RED_CYC - 1);
`ifdef PED_WALK_EN
            WALK:    cnt_lim = CNT_W'(WALK_CYC - 1);
`endif
            default: cnt_lim = CNT_W'(MAX_GREEN - 1);
        endcase
    end

    // Owner keeps green past MIN_GREEN while still requesting, up to MAX_GREEN.
    assign green_exit = (cnt_q >= CNT_W'(MIN_GREEN - 1)) && pick_valid
        && (!car_req[cur_q] || (cnt_q >= CNT_W'(MAX_GREEN - 1)));

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        cnt_d   = (cnt_q == cnt_lim) ? cnt_q : cnt_q + CNT_W'(1);
        case (state_q)
            GREEN: begin
                if (green_exit) begin
                    state_d = YELLOW;
                    nxt_d   = pick_idx;
                end
            end
            YELLOW: begin
                if (cnt_q == CNT_W'(YELLOW_CYC - 1)) begin
                    state_d = ALL_RED;
                end
            end
            ALL_RED: begin
                if (cnt_q == CNT_W'(ALL_RED_CYC - 1)) begin
`ifdef PED_WALK_EN
                    if (ped_pend_q) begin
                        state_d = WALK;
                    end else begin
                        state_d = GREEN;
                        cur_d   = nxt_q;
                    end
`else
                    state_d = GREEN;
                    cur_d   = nxt_q;
`endif
                end
            end
`ifdef PED_WALK_EN
            WALK: begin
                if (cnt_q == CNT_W'(WALK_CYC - 1)) begin
                    state_d = GREEN;
                    cur_d   = nxt_q;
                end
            end
`endif
            default: begin
                state_d = GREEN;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

`ifdef PED_WALK_EN
    // A request in the entry cycle of WALK still survives for the next change.
    always_comb begin
        ped_pend_d = ped_pend_q;
        if (state_d == WALK && state_q != WALK) begin
            ped_pend_d = 1'b0;
        end
        if (ped_req) begin
            ped_pend_d = 1'b1;
        end
    end

    assign walk = (state_q == WALK);
`endif

    always_comb begin
        for (int i = 0; i < N_APPROACH; i++) begin
            light[3*i +: 3] = LIGHT_R;
            if (IW'(i) == cur_q) begin
                if (state_q == GREEN) begin
                    light[3*i +: 3] = LIGHT_G;
                end else if (state_q == YELLOW) begin
                    light[3*i +: 3] = LIGHT_Y;
                end
            end
        end
        grant_idx   = cur_q;
        phase_state = state_q;
    end

endmodule
